// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
// -------------------
// Top-level sequencer for the RC4 brute-force key search. For every
// candidate key it runs the three datapath phases in strict order:
// s_memory init, KSA shuffle, then decrypt. Only one phase runs at a time,
// so each phase owns s_memory exclusively. While decrypt runs, the writes
// into decrypted_message are snooped and judged for printable plaintext.
// The key is stepped until a pass yields a clean message or the range ends.
//
// Handshake: every *_start output is a one-cycle pulse issued from a
// dedicated state. The matching *_done input is a one-cycle pulse that is
// only honoured in that phase's W_ state; a done arriving anywhere else is
// dropped. decrypt_abort is a one-cycle pulse that asks decrypt to stop
// early. Decrypt still answers it with decrypt_done.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   start                 begin a search (honoured in IDLE, FOUND, FAIL)
//   init_start/init_done  s_memory init FSM handshake
//   shuffle_start/_done   KSA shuffle FSM handshake
//   decrypt_start/_done   decrypt FSM handshake
//   decrypt_abort         early-termination request to decrypt
//   mon_wren, mon_data    snooped decrypted_message write port
//   secret_key            current candidate key
//   busy, found, fail     search status
module rc4_key_search_ctrl #(
    parameter int                     KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0]   KEY_START = 24'h000000,
    parameter logic [KEY_WIDTH-1:0]   KEY_END   = 24'h3FFFFF,
    parameter logic [KEY_WIDTH-1:0]   KEY_STEP  = 24'h000001,
    parameter int                     MSG_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 init_start,
    input  logic                 init_done,
    output logic                 shuffle_start,
    input  logic                 shuffle_done,
    output logic                 decrypt_start,
    output logic                 decrypt_abort,
    input  logic                 decrypt_done,
    input  logic                 mon_wren,
    input  logic [7:0]           mon_data,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 found,
    output logic                 fail
);

    localparam int CNT_W = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0] MSG_LEN_C = CNT_W'(MSG_LEN);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_W_INIT = 4'd2,
        S_SHUF   = 4'd3,
        S_W_SHUF = 4'd4,
        S_DEC    = 4'd5,
        S_W_DEC  = 4'd6,
        S_CHECK  = 4'd7,
        S_NEXT   = 4'd8,
        S_FOUND  = 4'd9,
        S_FAIL   = 4'd10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             bad_flag;
    logic [CNT_W-1:0] byte_cnt;
    logic             key_load;
    logic             key_step;
    logic             pass_clear;
    logic             byte_valid;
    logic             snoop;
    // One extra bit so that stepping past the top of the key space is
    // detected instead of wrapping around to a small key.
    logic [KEY_WIDTH:0] key_next;

    assign byte_valid = ((mon_data >= 8'h61) && (mon_data <= 8'h7A)) || (mon_data == 8'h20);
    // Snooping is active in W_DEC, including the cycle in which decrypt_done
    // arrives, so a final write coincident with done is still judged.
    assign snoop      = (state == S_W_DEC) && mon_wren;
    assign key_next   = {1'b0, secret_key} + {1'b0, KEY_STEP};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_next    = state;
        init_start    = 1'b0;
        shuffle_start = 1'b0;
        decrypt_start = 1'b0;
        busy          = 1'b1;
        found         = 1'b0;
        fail          = 1'b0;
        key_load      = 1'b0;
        key_step      = 1'b0;
        pass_clear    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_INIT;
                end
            end
            S_FOUND: begin
                busy  = 1'b0;
                found = 1'b1;
                if (start) begin
                    key_load   = 1'b1;
                    state_next = S_INIT;
                end
            end
            S_FAIL: begin
                busy = 1'b0;
                fail = 1'b1;
                if (start) begin
                    key_load   = 1'b1;
                    state_next = S_INIT;
                end
            end
            S_INIT: begin
                init_start = 1'b1;
                state_next = S_W_INIT;
            end
            S_W_INIT: begin
                if (init_done) begin
                    state_next = S_SHUF;
                end
            end
            S_SHUF: begin
                shuffle_start = 1'b1;
                state_next    = S_W_SHUF;
            end
            S_W_SHUF: begin
                if (shuffle_done) begin
                    state_next = S_DEC;
                end
            end
            S_DEC: begin
                decrypt_start = 1'b1;
                pass_clear    = 1'b1;
                state_next    = S_W_DEC;
            end
            S_W_DEC: begin
                if (decrypt_done) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!bad_flag && (byte_cnt == MSG_LEN_C)) begin
                    state_next = S_FOUND;
                end else begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                // On exhaustion the key is left on the last one tried.
                if (key_next > {1'b0, KEY_END}) begin
                    state_next = S_FAIL;
                end else begin
                    key_step   = 1'b1;
                    state_next = S_INIT;
                end
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Plaintext judging and abort pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_flag      <= 1'b0;
            byte_cnt      <= '0;
            decrypt_abort <= 1'b0;
        end else begin
            // Abort only on the first bad byte of a pass. If decrypt is
            // already reporting done there is nothing left to abort.
            decrypt_abort <= snoop && !byte_valid && !bad_flag && !decrypt_done;
            if (pass_clear) begin
                bad_flag <= 1'b0;
                byte_cnt <= '0;
            end else if (snoop) begin
                if (byte_cnt != MSG_LEN_C) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
                if (!byte_valid) begin
                    bad_flag <= 1'b1;
                end
            end
        end
    end

    // Candidate key: changes only on reload at start or in NEXT, so it is
    // stable across a whole init/shuffle/decrypt pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            secret_key <= KEY_START;
        end else if (key_load) begin
            secret_key <= KEY_START;
        end else if (key_step) begin
            secret_key <= key_next[KEY_WIDTH-1:0];
        end
    end

endmodule
